// File: rtl/bsg_counter_dynamic_limit_multi_en.sv
// Bank of independent up-counters, each terminating at its own run-time limit.
// A limit of 0 gives a full 2^width_p period; saturate_p picks wrap-to-zero or hold at terminal.
module bsg_counter_dynamic_limit_multi_en #(
  parameter int width_p    = 16,
  parameter int els_p      = 4,
  parameter int saturate_p = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         en_i,
  input  logic [els_p-1:0]         clear_i,
  input  logic [els_p*width_p-1:0] limit_i,
  output logic [els_p*width_p-1:0] counter_o,
  output logic [els_p-1:0]         overflowed_o,
  output logic [els_p-1:0]         wrap_o,
  output logic                     any_overflowed_o
);

  for (genvar gi = 0; gi < els_p; gi++) begin : g_ch
    logic [width_p-1:0] r_count;
    logic               r_wrap;
    logic [width_p-1:0] w_plus1;
    logic [width_p-1:0] w_limit;
    logic               w_ovf;
    logic               w_term;

    // Truncated increment makes limit 0 behave as 2^width_p with no special case.
    assign w_plus1 = r_count + width_p'(1);
    assign w_limit = limit_i[gi*width_p +: width_p];
    assign w_ovf   = (w_plus1 == w_limit);
    assign w_term  = en_i[gi] & w_ovf & ~clear_i[gi];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_count <= '0;
        r_wrap  <= 1'b0;
      end else begin
        r_wrap <= w_term;
        if (clear_i[gi]) begin
          r_count <= '0;
        end else if (en_i[gi] && !w_ovf) begin
          r_count <= w_plus1;
        end else if (w_term && (saturate_p == 0)) begin
          r_count <= '0;
        end
      end
    end

    assign counter_o[gi*width_p +: width_p] = r_count;
    assign overflowed_o[gi]                 = w_ovf;
    assign wrap_o[gi]                       = r_wrap;
  end

  assign any_overflowed_o = |overflowed_o;

endmodule

// File: tb/tb_bsg_counter_dynamic_limit_multi_en.sv
// Scoreboard bench: driver queues hand-computed per-channel expectations for the next edge,
// a monitor pops and compares them just after each rising edge.
module tb_bsg_counter_dynamic_limit_multi_en;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en_w, clr_w;
  logic [63:0] lim_w;
  logic [1:0]  en_n, clr_n;
  logic [15:0] lim_n;

  logic [63:0] cnt_w, cnt_s;
  logic [3:0]  ovf_w, wrap_w, ovf_s, wrap_s;
  logic        any_w, any_s;
  logic [15:0] cnt_n;
  logic [1:0]  ovf_n, wrap_n;
  logic        any_n;

  always #5 clk = ~clk;

  bsg_counter_dynamic_limit_multi_en #(.width_p(16), .els_p(4), .saturate_p(0)) dut_w (
    .clk_i(clk), .reset_i(reset), .en_i(en_w), .clear_i(clr_w), .limit_i(lim_w),
    .counter_o(cnt_w), .overflowed_o(ovf_w), .wrap_o(wrap_w), .any_overflowed_o(any_w));

  bsg_counter_dynamic_limit_multi_en #(.width_p(16), .els_p(4), .saturate_p(1)) dut_s (
    .clk_i(clk), .reset_i(reset), .en_i(en_w), .clear_i(clr_w), .limit_i(lim_w),
    .counter_o(cnt_s), .overflowed_o(ovf_s), .wrap_o(wrap_s), .any_overflowed_o(any_s));

  bsg_counter_dynamic_limit_multi_en #(.width_p(8), .els_p(2), .saturate_p(0)) dut_n (
    .clk_i(clk), .reset_i(reset), .en_i(en_n), .clear_i(clr_n), .limit_i(lim_n),
    .counter_o(cnt_n), .overflowed_o(ovf_n), .wrap_o(wrap_n), .any_overflowed_o(any_n));

  typedef struct {
    int cyc;
    int dut;   // 0 = wrap 16b, 1 = saturate 16b, 2 = wrap 8b
    int ch;    // -1 = check any_overflowed_o against ovf
    int cnt;
    bit ovf;
    bit wr;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_ch(input int d, input int ch, input int cnt, input bit ovf, input bit wr);
    exp_t e;
    e.cyc = cyc + 1;
    e.dut = d;
    e.ch  = ch;
    e.cnt = cnt;
    e.ovf = ovf;
    e.wr  = wr;
    sb.push_back(e);
  endtask

  task automatic expect_any(input int d, input bit v);
    expect_ch(d, -1, 0, v, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   ac;
    bit   ao, aw;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e  = sb.pop_front();
        ac = 0;
        ao = 1'b0;
        aw = 1'b0;
        case (e.dut)
          0: if (e.ch < 0) ao = any_w;
             else begin ac = int'(cnt_w[e.ch*16 +: 16]); ao = ovf_w[e.ch]; aw = wrap_w[e.ch]; end
          1: if (e.ch < 0) ao = any_s;
             else begin ac = int'(cnt_s[e.ch*16 +: 16]); ao = ovf_s[e.ch]; aw = wrap_s[e.ch]; end
          default: if (e.ch < 0) ao = any_n;
             else begin ac = int'(cnt_n[e.ch*8 +: 8]); ao = ovf_n[e.ch]; aw = wrap_n[e.ch]; end
        endcase
        if (e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_expectation dut%0d ch%0d queued for cycle %0d, seen at cycle %0d",
                   e.dut, e.ch, e.cyc, cyc);
        end else if (e.ch < 0) begin
          checks++;
          $display("cyc %0d dut%0d any_overflowed got %0b want %0b", cyc, e.dut, ao, e.ovf);
          if (ao !== e.ovf) begin
            errors++;
            $display("FAIL any_overflowed dut%0d got %0b want %0b", e.dut, ao, e.ovf);
          end
        end else begin
          checks += 3;
          $display("cyc %0d dut%0d ch%0d cnt %0d/%0d ovf %0b/%0b wrap %0b/%0b",
                   cyc, e.dut, e.ch, ac, e.cnt, ao, e.ovf, aw, e.wr);
          if (ac != e.cnt) begin
            errors++;
            $display("FAIL counter dut%0d ch%0d got %0d want %0d", e.dut, e.ch, ac, e.cnt);
          end
          if (ao !== e.ovf) begin
            errors++;
            $display("FAIL overflowed dut%0d ch%0d got %0b want %0b", e.dut, e.ch, ao, e.ovf);
          end
          if (aw !== e.wr) begin
            errors++;
            $display("FAIL wrap dut%0d ch%0d got %0b want %0b", e.dut, e.ch, aw, e.wr);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    repeat (90000) @(posedge clk);
    errors++;
    $display("FAIL timeout cycle budget exhausted with %0d expectations pending", sb.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic rst_cycle();
    reset = 1'b1;
    en_w  = '0;
    clr_w = '0;
    en_n  = '0;
    clr_n = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver
  initial begin
    int c2[12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
    bit w2[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int cs[6]  = '{1, 2, 2, 2, 2, 2};
    bit ws[6]  = '{0, 0, 1, 1, 1, 1};
    bit os[6]  = '{0, 1, 1, 1, 1, 1};
    int cw[6]  = '{1, 2, 0, 1, 2, 0};
    bit ww[6]  = '{0, 0, 1, 0, 0, 1};
    bit ow[6]  = '{0, 1, 0, 0, 1, 0};

    reset = 1'b1;
    en_w  = '0;
    clr_w = '0;
    en_n  = '0;
    clr_n = '0;
    lim_w = {16'd1, 16'd4, 16'd3, 16'd5};
    lim_n = {8'd0, 8'd0};
    @(negedge clk);

    // Reset state: counters/wrap cleared, overflowed only where limit is 1
    expect_ch(0, 0, 0, 1'b0, 1'b0);
    expect_ch(0, 1, 0, 1'b0, 1'b0);
    expect_ch(0, 2, 0, 1'b0, 1'b0);
    expect_ch(0, 3, 0, 1'b1, 1'b0);
    expect_any(0, 1'b1);
    expect_ch(2, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Wrap mode, limit 5 on ch0
    en_w = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      expect_ch(0, 0, c2[k], (c2[k] == 4), w2[k]);
      @(negedge clk);
    end

    // Limit 3 on ch1: saturate instance holds, wrap instance rolls over
    rst_cycle();
    en_w = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      expect_ch(1, 1, cs[k], os[k], ws[k]);
      expect_ch(0, 1, cw[k], ow[k], ww[k]);
      @(negedge clk);
    end
    en_w = 4'b0000;
    expect_ch(1, 1, 2, 1'b1, 1'b0);
    @(negedge clk);

    // Clear beats enable at terminal count on ch2 (limit 4)
    rst_cycle();
    en_w = 4'b0100;
    expect_ch(0, 2, 1, 1'b0, 1'b0); @(negedge clk);
    expect_ch(0, 2, 2, 1'b0, 1'b0); @(negedge clk);
    expect_ch(0, 2, 3, 1'b1, 1'b0); @(negedge clk);
    clr_w = 4'b0100;
    expect_ch(0, 2, 0, 1'b0, 1'b0); @(negedge clk);
    clr_w = 4'b0000;
    expect_ch(0, 2, 1, 1'b0, 1'b0); @(negedge clk);
    en_w  = 4'b0000;
    clr_w = 4'b0100;
    expect_ch(0, 2, 0, 1'b0, 1'b0); @(negedge clk);
    clr_w = 4'b0000;

    // Limit 1 on ch3: stuck at 0, wrap every enabled cycle
    rst_cycle();
    en_w = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      expect_ch(0, 3, 0, 1'b1, 1'b1);
      @(negedge clk);
    end
    en_w = 4'b0000;
    expect_ch(0, 3, 0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset mid-count with all enables high
    lim_w = {16'd20, 16'd20, 16'd20, 16'd20};
    rst_cycle();
    en_w = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) for (int ch = 0; ch < 4; ch++) expect_ch(0, ch, 5, 1'b0, 1'b0);
      @(negedge clk);
    end
    reset = 1'b1;
    for (int ch = 0; ch < 4; ch++) expect_ch(0, ch, 0, 1'b0, 1'b0);
    expect_any(0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int ch = 0; ch < 4; ch++) expect_ch(0, ch, 1, 1'b0, 1'b0);
    @(negedge clk);

    // Limit dropped below the count on ch3, then raised to land on terminal
    rst_cycle();
    en_w = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) expect_ch(0, 3, 10, 1'b0, 1'b0);
      @(negedge clk);
    end
    lim_w[48 +: 16] = 16'd5;
    expect_ch(0, 3, 11, 1'b0, 1'b0); @(negedge clk);
    expect_ch(0, 3, 12, 1'b0, 1'b0); @(negedge clk);
    expect_ch(0, 3, 13, 1'b0, 1'b0); @(negedge clk);
    lim_w[48 +: 16] = 16'd15;
    expect_ch(0, 3, 14, 1'b1, 1'b0); @(negedge clk);
    expect_ch(0, 3, 0, 1'b0, 1'b1);  @(negedge clk);
    en_w = 4'b0000;

    // 8-bit instance: limit drop 20 -> 5 at count 10 runs through 255 and wraps
    rst_cycle();
    lim_n = {8'd0, 8'd20};
    en_n  = 2'b01;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    lim_n[7:0] = 8'd5;
    for (int k = 1; k <= 251; k++) begin
      if (k == 1)   expect_ch(2, 0, 11, 1'b0, 1'b0);
      if (k == 245) expect_ch(2, 0, 255, 1'b0, 1'b0);
      if (k == 246) expect_ch(2, 0, 0, 1'b0, 1'b0);
      if (k == 250) expect_ch(2, 0, 4, 1'b1, 1'b0);
      if (k == 251) expect_ch(2, 0, 0, 1'b0, 1'b1);
      @(negedge clk);
    end

    // 8-bit instance: limit 0 on ch1 is a 256-cycle period; ch0 idle stays put
    rst_cycle();
    en_n = 2'b10;
    for (int k = 1; k <= 257; k++) begin
      if (k == 255) begin
        expect_ch(2, 1, 255, 1'b1, 1'b0);
        expect_any(2, 1'b1);
      end
      if (k == 256) begin
        expect_ch(2, 1, 0, 1'b0, 1'b1);
        expect_ch(2, 0, 0, 1'b0, 1'b0);
      end
      if (k == 257) expect_ch(2, 1, 1, 1'b0, 1'b0);
      @(negedge clk);
    end

    // 16-bit limit 0 on ch0: full 65536-cycle period
    rst_cycle();
    lim_w[15:0] = 16'd0;
    en_w = 4'b0001;
    for (int k = 1; k <= 65536; k++) begin
      if (k == 65535) begin
        expect_ch(0, 0, 65535, 1'b1, 1'b0);
        expect_any(0, 1'b1);
      end
      if (k == 65536) expect_ch(0, 0, 0, 1'b0, 1'b1);
      @(negedge clk);
    end
    en_w = 4'b0000;

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d expectations never checked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
